// File: rtl/data_ram_pkg.sv
// Shared op codes and memory-map constants for the data RAM.
// Optional feature macro used by data_ram: DRAM_HALT_MMIO_EN.
package data_ram_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'h0,
        OP_LH  = 4'h1,
        OP_LW  = 4'h2,
        OP_LBU = 4'h4,
        OP_LHU = 4'h5,
        OP_SB  = 4'h8,
        OP_SH  = 4'h9,
        OP_SW  = 4'hA
    } mem_op_e;

    localparam int          XLEN             = 32;
    localparam int          OP_W             = 4;
    localparam logic [31:0] ZERO             = 32'h0000_0000;
    localparam int          DRAM_DEPTH_WORDS = 4096;
    localparam logic [31:0] DRAM_BASE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] HALT_ADDR        = 32'hFFFF_FFF0;

endpackage

// File: rtl/dram_lane_align.sv
// Combinational lane steering: store byte enables / replication, load lane
// extraction with sign or zero extension, and per-op alignment check.
module dram_lane_align
    import data_ram_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [XLEN-1:0] rd_word_i,
    output logic            is_load_o,
    output logic            is_store_o,
    output logic            aligned_o,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic [XLEN-1:0] ld_data_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rd_word_i[{off_i, 3'b000} +: 8];
    assign rd_half = rd_word_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        aligned_o  = 1'b0;
        be_o       = 4'b0000;
        wr_data_o  = ZERO;
        ld_data_o  = ZERO;
        case (op_i)
            OP_LB: begin
                is_load_o = 1'b1;
                aligned_o = 1'b1;
                ld_data_o = {{24{rd_byte[7]}}, rd_byte};
            end
            OP_LBU: begin
                is_load_o = 1'b1;
                aligned_o = 1'b1;
                ld_data_o = {24'h0, rd_byte};
            end
            OP_LH: begin
                is_load_o = 1'b1;
                aligned_o = ~off_i[0];
                ld_data_o = {{16{rd_half[15]}}, rd_half};
            end
            OP_LHU: begin
                is_load_o = 1'b1;
                aligned_o = ~off_i[0];
                ld_data_o = {16'h0, rd_half};
            end
            OP_LW: begin
                is_load_o = 1'b1;
                aligned_o = (off_i == 2'b00);
                ld_data_o = rd_word_i;
            end
            OP_SB: begin
                is_store_o = 1'b1;
                aligned_o  = 1'b1;
                be_o       = 4'b0001 << off_i;
                wr_data_o  = {4{st_data_i[7:0]}};
            end
            OP_SH: begin
                is_store_o = 1'b1;
                aligned_o  = ~off_i[0];
                be_o       = 4'b0011 << off_i;
                wr_data_o  = {2{st_data_i[15:0]}};
            end
            OP_SW: begin
                is_store_o = 1'b1;
                aligned_o  = (off_i == 2'b00);
                be_o       = 4'b1111;
                wr_data_o  = st_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// Zero-wait data RAM responder: async-read word array, byte-enabled writes,
// sticky fault capture. DRAM_HALT_MMIO_EN adds the sticky MMIO halt register.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int          DEPTH_WORDS = DRAM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DRAM_BASE_ADDR,
    parameter logic [31:0] HALT_ADDR   = data_ram_pkg::HALT_ADDR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ram_request_i,
    input  logic            ram_w_request_i,
    input  logic [31:0]     ram_addr_i,
    input  logic [31:0]     ram_data_i,
    input  logic [OP_W-1:0] ram_op_i,
    output logic [31:0]     ram_data_o,
    input  logic            fault_clr_i,
    output logic            fault_o,
    output logic [31:0]     fault_addr_o,
    output logic            halt_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      idx_full;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      rd_word;
    logic             is_load, is_store, aligned;
    logic [3:0]       be;
    logic [31:0]      wr_data, ld_data;
    logic             access_ok, load_ok, wr_en, fault_now;
    logic             halt_st, halt_ld;
    logic             fault_q, fault_d;
    logic [31:0]      fault_addr_q, fault_addr_d;

    // Subtraction wraps addresses below BASE_ADDR to huge indices -> out of range.
    assign idx_full = (ram_addr_i - BASE_ADDR) >> 2;
    assign idx      = idx_full[IDX_W-1:0];
    assign in_range = (idx_full < 32'(DEPTH_WORDS));
    assign rd_word  = mem_q[idx];

    dram_lane_align u_lane (
        .op_i       (ram_op_i),
        .off_i      (ram_addr_i[1:0]),
        .st_data_i  (ram_data_i),
        .rd_word_i  (rd_word),
        .is_load_o  (is_load),
        .is_store_o (is_store),
        .aligned_o  (aligned),
        .be_o       (be),
        .wr_data_o  (wr_data),
        .ld_data_o  (ld_data)
    );

`ifdef DRAM_HALT_MMIO_EN
    logic halt_q;

    assign halt_st = ram_request_i & ram_w_request_i & (ram_op_i == OP_SW)
                   & (ram_addr_i == HALT_ADDR);
    assign halt_ld = ram_request_i & ~ram_w_request_i & is_load
                   & (ram_addr_i == HALT_ADDR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halt_q <= 1'b0;
        end else if (halt_st) begin
            halt_q <= 1'b1;
        end
    end

    assign halt_o = halt_q;
`else
    assign halt_st = 1'b0;
    assign halt_ld = 1'b0;
    assign halt_o  = 1'b0;
`endif

    assign access_ok = aligned & in_range;
    assign load_ok   = ram_request_i & ~ram_w_request_i & is_load & access_ok & ~halt_ld;
    assign wr_en     = ram_request_i & ram_w_request_i & is_store & access_ok
                     & ~halt_st & ~rst_i;
    assign fault_now = ram_request_i & (is_load | is_store) & ~access_ok
                     & ~halt_st & ~halt_ld;

    always_comb begin
        ram_data_o = ZERO;
        if (rst_i) begin
            ram_data_o = ZERO;
        end else if (halt_ld) begin
            ram_data_o = {31'b0, halt_o};
        end else if (load_ok) begin
            ram_data_o = ld_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // A new fault beats a same-cycle clear and recaptures its address.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (fault_now) begin
            fault_d = 1'b1;
            if (!fault_q || fault_clr_i) begin
                fault_addr_d = ram_addr_i;
            end
        end else if (fault_clr_i) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q      <= 1'b0;
            fault_addr_q <= ZERO;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed scenarios plus randomized traffic
// against a byte-level reference model.
module tb_data_ram;
    import data_ram_pkg::*;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] HADDR = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  op = 4'h3;
    logic        clr = 1'b0;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] fault_addr;
    logic        halt;

    int total = 0;
    int bad = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic        mf = 1'b0;
    logic [31:0] mfa = '0;
    logic        mhalt = 1'b0;

    data_ram dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ram_request_i   (req),
        .ram_w_request_i (we),
        .ram_addr_i      (addr),
        .ram_data_i      (wdata),
        .ram_op_i        (op),
        .ram_data_o      (rdata),
        .fault_clr_i     (clr),
        .fault_o         (fault),
        .fault_addr_o    (fault_addr),
        .halt_o          (halt)
    );

    always #5 clk = ~clk;

    function automatic int op_bytes(input logic [3:0] o);
        case (o)
            4'h0, 4'h4, 4'h8: return 1;
            4'h1, 4'h5, 4'h9: return 2;
            4'h2, 4'hA:       return 4;
            default:          return 0;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        total++;
        if (fault !== mf) begin
            bad++;
            $display("FAIL %s fault_o: got %b want %b", tag, fault, mf);
        end
        total++;
        if (fault_addr !== mfa) begin
            bad++;
            $display("FAIL %s fault_addr_o: got %h want %h", tag, fault_addr, mfa);
        end
        total++;
        if (halt !== mhalt) begin
            bad++;
            $display("FAIL %s halt_o: got %b want %b", tag, halt, mhalt);
        end
    endtask

    // One cycle of traffic: drive at negedge, check load data mid-cycle,
    // advance the model at posedge and check the sticky registers after it.
    task automatic access(input bit r, input bit w, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit c, input string tag);
        int          n, off;
        bit          is_ld, is_st, al, inr, hst, hld, flt, wr;
        logic [31:0] idx, exp, word, mask;
        @(negedge clk);
        req = r; we = w; op = o; addr = a; wdata = d; clr = c;
        n     = op_bytes(o);
        is_ld = (n > 0) && (o[3] == 1'b0);
        is_st = (n > 0) && (o[3] == 1'b1);
        off   = int'(a[1:0]);
        idx   = (a - BASE) / 4;
        inr   = idx < DEPTH;
        al    = (n > 0) && ((off % n) == 0);
        hst   = 1'b0;
        hld   = 1'b0;
`ifdef DRAM_HALT_MMIO_EN
        hst = r && w && (o == 4'hA) && (a == HADDR);
        hld = r && !w && is_ld && (a == HADDR);
`endif
        flt = r && (n > 0) && !(al && inr) && !hst && !hld;
        wr  = r && w && is_st && al && inr && !hst;
        exp = '0;
        if (hld) begin
            exp = {31'b0, mhalt};
        end else if (r && !w && is_ld && al && inr) begin
            word = mdl_mem[idx];
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
            exp  = (word >> (8 * off)) & mask;
            if ((o == 4'h0 || o == 4'h1) && exp[8*n-1]) exp = exp | ~mask;
        end
        #2;
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL %s ram_data_o: got %h want %h", tag, rdata, exp);
        end
        @(posedge clk);
        #1;
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                mdl_mem[idx][8*(off+k) +: 8] = d[8*k +: 8];
            end
        end
        if (flt) begin
            if (!mf || c) mfa = a;
            mf = 1'b1;
        end else if (c) begin
            mf = 1'b0;
        end
        if (hst) mhalt = 1'b1;
        check_regs(tag);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 4'h3, 32'h0, 32'h0, 1'b0, "idle");
    endtask

    task automatic test_reset();
        req = 1'b1; we = 1'b0; op = 4'h2; addr = 32'h10; rst = 1'b1;
        #3;
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset ram_data_o: got %h want 0", rdata);
        end
        check_regs("reset");
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < 16; i++) access(1'b1, 1'b1, 4'hA, 32'(4 * i), 32'h0, 1'b0, "init");
    endtask

    task automatic test_store_load();
        access(1'b1, 1'b1, 4'hA, 32'h10, 32'h1122_3344, 1'b0, "sw10");
        access(1'b1, 1'b0, 4'h2, 32'h10, 32'h0, 1'b0, "lw10");
        total++;
        if (rdata !== 32'h1122_3344 && fault !== 1'b0) begin
            bad++;
            $display("FAIL raw_lw: got %h want 11223344", rdata);
        end
        access(1'b1, 1'b1, 4'hA, 32'h10, 32'h0, 1'b0, "sw10_0");
        access(1'b1, 1'b1, 4'h8, 32'h13, 32'h0000_0080, 1'b0, "sb13");
        access(1'b1, 1'b0, 4'h0, 32'h13, 32'h0, 1'b0, "lb13");
        access(1'b1, 1'b0, 4'h4, 32'h13, 32'h0, 1'b0, "lbu13");
        access(1'b1, 1'b0, 4'h2, 32'h10, 32'h0, 1'b0, "lw10_b");
        access(1'b1, 1'b1, 4'hA, 32'h20, 32'hA5A5_A5A5, 1'b0, "sw20");
        access(1'b1, 1'b1, 4'h9, 32'h22, 32'h0000_BEEF, 1'b0, "sh22");
        access(1'b1, 1'b0, 4'h1, 32'h22, 32'h0, 1'b0, "lh22");
        access(1'b1, 1'b0, 4'h5, 32'h22, 32'h0, 1'b0, "lhu22");
        access(1'b1, 1'b0, 4'h2, 32'h20, 32'h0, 1'b0, "lw20");
        access(1'b1, 1'b0, 4'hA, 32'h20, 32'h0, 1'b0, "sw_we0");
        access(1'b1, 1'b1, 4'h2, 32'h20, 32'hFFFF_FFFF, 1'b0, "lw_we1");
        access(1'b1, 1'b0, 4'h2, 32'h20, 32'h0, 1'b0, "lw20_c");
    endtask

    task automatic test_fault();
        access(1'b0, 1'b0, 4'h3, 32'h0, 32'h0, 1'b1, "pre_clr");
        access(1'b1, 1'b0, 4'h2, 32'h11, 32'h0, 1'b0, "lw11");
        access(1'b1, 1'b1, 4'h9, 32'h21, 32'h1234, 1'b0, "sh21");
        access(1'b1, 1'b0, 4'h2, 32'h20, 32'h0, 1'b0, "lw20_kept");
        access(1'b1, 1'b1, 4'hA, BASE + 32'(4 * DEPTH), 32'h5, 1'b1, "clr_new");
        access(1'b0, 1'b0, 4'h3, 32'h0, 32'h0, 1'b1, "clr_only");
        access(1'b1, 1'b0, 4'h2, BASE - 32'd4, 32'h0, 1'b0, "wrap_below");
        access(1'b0, 1'b0, 4'h3, 32'h0, 32'h0, 1'b1, "post_clr");
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'h3};
        logic [31:0] a;
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = 32'($urandom_range(0, 63));
            else if (sel == 8) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
            else               a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 3));
            access($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                   ops[$urandom_range(0, 8)], a, $urandom,
                   $urandom_range(0, 15) == 0, "rand");
        end
    endtask

    task automatic test_reset_mid();
        access(1'b1, 1'b1, 4'hA, 32'h30, 32'hCAFE_F00D, 1'b0, "sw30");
        access(1'b1, 1'b0, 4'h2, 32'h31, 32'h0, 1'b0, "lw31_fault");
        @(negedge clk);
        req = 1'b1; we = 1'b1; op = 4'hA; addr = 32'h30; wdata = 32'h0BAD_0BAD; clr = 1'b0;
        #2;
        rst = 1'b1;
        mf = 1'b0; mfa = '0; mhalt = 1'b0;
        #1;
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid ram_data_o: got %h want 0", rdata);
        end
        check_regs("rst_mid");
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        access(1'b1, 1'b0, 4'h2, 32'h30, 32'h0, 1'b0, "lw30_after_rst");
    endtask

    task automatic test_halt();
        access(1'b0, 1'b0, 4'h3, 32'h0, 32'h0, 1'b1, "halt_pre_clr");
        access(1'b1, 1'b1, 4'hA, HADDR, 32'h1, 1'b0, "sw_halt");
        access(1'b1, 1'b0, 4'h2, HADDR, 32'h0, 1'b0, "lw_halt");
        idle();
    endtask

    initial begin
        test_reset();
        test_init();
        test_store_load();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
